// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: framed byte capture, E0/F0 prefix decoding and held-state tracking for a key table.
// Optional macro PS2_TYPEMATIC_EN: repeated make codes for a held key re-pulse key_press.
module ps2_key_decoder #(
    parameter int                    NUM_KEYS       = 8,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h174, 9'h172, 9'h16B, 9'h175,
                                                       9'h023, 9'h01B, 9'h01C, 9'h01D},
    parameter int                    TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic                rx_valid,
    output logic [7:0]          rx_byte,
    output logic                frame_err,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [2:0]          clk_sync;
    logic [1:0]          data_sync;
    logic                fall;
    logic                data_bit;

    state_t              state, state_next;
    logic [2:0]          bit_cnt, bit_cnt_next;
    logic [7:0]          shift, shift_next;
    logic                parity, parity_next;
    logic [TW-1:0]       timer, timer_next;
    logic                good, bad;

    logic                ext, brk;
    logic [NUM_KEYS-1:0] match;

    // Bus idles high, so the synchronisers reset to 1 to avoid a false falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign fall     = clk_sync[2] & ~clk_sync[1];
    assign data_bit = data_sync[1];

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        parity_next  = parity;
        good         = 1'b0;
        bad          = 1'b0;
        timer_next   = (state == IDLE || fall) ? '0 : timer + 1'b1;
        // A stalled frame is abandoned even if an edge happens to arrive in the same cycle.
        if (state != IDLE && timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state_next = IDLE;
            bad        = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_bit) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    shift_next   = {data_bit, shift[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_next = PARITY;
                end
                PARITY: begin
                    parity_next = data_bit;
                    state_next  = STOP;
                end
                STOP: begin
                    good       = data_bit & (^shift ^ parity);
                    bad        = ~good;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            parity    <= 1'b0;
            timer     <= '0;
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            shift     <= shift_next;
            parity    <= parity_next;
            timer     <= timer_next;
            rx_valid  <= good;
            frame_err <= bad;
            if (good) rx_byte <= shift;
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            match[i] = ({ext, rx_byte} == KEY_CODES[9*i +: 9]);
    end

    // Prefix flags persist until a non-prefix byte (or a bad frame) consumes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext         <= 1'b0;
            brk         <= 1'b0;
            key_down    <= '0;
            key_press   <= '0;
            key_release <= '0;
        end else begin
            key_press   <= '0;
            key_release <= '0;
            if (frame_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == 8'hE0) begin
                    ext <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    brk <= 1'b1;
                end else if (rx_byte == 8'hAA && !ext && !brk) begin
                    key_down <= '0;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (brk) begin
                        key_down    <= key_down & ~match;
                        key_release <= key_down & match;
                    end else begin
                        key_down  <= key_down | match;
`ifdef PS2_TYPEMATIC_EN
                        key_press <= match;
`else
                        key_press <= match & ~key_down;
`endif
                    end
                end
            end
        end
    end

endmodule
